matrix_add_ctrl: RTL and testbench

Sequencing controller for the combinational int8 matrix adder. It accepts a start command and a matrix size, then loads operands A and B one element per handshake. It drives the adder's 200-bit packed operand buses, registers the sum and overflow, and streams the result out one element per handshake. It sits between the byte-wide host/bus side and the adder datapath, which is instantiated outside this block.

---
 rtl/matrix_add_ctrl.sv | 164 ++++++++++++++++
 tb/tb_matrix_add_ctrl.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_add_ctrl.sv
// matrix_add_ctrl: load/compute/drain sequencer for the external 5x5 int8 matrix adder.
// Define MADD_ELEM_OVF_EN to build per-element overflow detection on out_ovf.
`default_nettype none

module matrix_add_ctrl (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [1:0]   size,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [7:0]   in_data,
  output logic [199:0] add_a,
  output logic [199:0] add_b,
  output logic [1:0]   add_size,
  input  logic [199:0] add_result,
  input  logic         add_overflow,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [7:0]   out_data,
  output logic         out_last,
  output logic         out_ovf,
  output logic         busy,
  output logic         done,
  output logic         overflow
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD_A  = 3'd1,
    S_LOAD_B  = 3'd2,
    S_COMPUTE = 3'd3,
    S_DRAIN   = 3'd4
  } state_t;

  state_t         r_state;
  state_t         w_next;
  logic [1:0]     r_size;
  logic [4:0]     r_idx;
  logic [4:0]     r_k;
  logic [199:0]   r_a;
  logic [199:0]   r_b;
  logic [199:0]   r_res;
  logic           r_ovf;
  logic           r_done;

  logic [4:0]     w_last_idx;
  logic           w_in_hs;
  logic           w_out_hs;
  logic [7:0]     w_idx_lsb;
  logic [7:0]     w_k_lsb;

  // Final element index per size, as a lookup rather than a multiply.
  always_comb begin
    w_last_idx = 5'd3;
    case (r_size)
      2'b00:   w_last_idx = 5'd3;
      2'b01:   w_last_idx = 5'd8;
      2'b10:   w_last_idx = 5'd15;
      default: w_last_idx = 5'd24;
    endcase
  end

  assign in_ready  = (r_state == S_LOAD_A) || (r_state == S_LOAD_B);
  assign out_valid = (r_state == S_DRAIN);
  assign busy      = (r_state != S_IDLE);
  assign done      = r_done;
  assign overflow  = r_ovf;
  assign add_a     = r_a;
  assign add_b     = r_b;
  assign add_size  = r_size;

  assign w_in_hs   = in_valid && in_ready;
  assign w_out_hs  = out_valid && out_ready;
  assign w_idx_lsb = {r_idx, 3'b000};
  assign w_k_lsb   = {r_k, 3'b000};

  // Output element is selected purely by k, so it holds while out_ready is low.
  assign out_data  = r_res[w_k_lsb +: 8];
  assign out_last  = out_valid && (r_k == w_last_idx);

`ifdef MADD_ELEM_OVF_EN
  logic [7:0] w_a_k;
  logic [7:0] w_b_k;
  assign w_a_k   = r_a[w_k_lsb +: 8];
  assign w_b_k   = r_b[w_k_lsb +: 8];
  assign out_ovf = out_valid && (w_a_k[7] == w_b_k[7]) && (out_data[7] != w_a_k[7]);
`else
  assign out_ovf = 1'b0;
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (start) w_next = S_LOAD_A;
      S_LOAD_A:  if (w_in_hs && (r_idx == w_last_idx)) w_next = S_LOAD_B;
      S_LOAD_B:  if (w_in_hs && (r_idx == w_last_idx)) w_next = S_COMPUTE;
      S_COMPUTE: w_next = S_DRAIN;
      S_DRAIN:   if (w_out_hs && (r_k == w_last_idx)) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_size  <= 2'b00;
      r_idx   <= 5'd0;
      r_k     <= 5'd0;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_ovf   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_size <= size;
            r_idx  <= 5'd0;
            r_k    <= 5'd0;
            r_a    <= '0;
            r_b    <= '0;
            r_res  <= '0;
            r_ovf  <= 1'b0;
          end
        end
        S_LOAD_A: begin
          if (w_in_hs) begin
            r_a[w_idx_lsb +: 8] <= in_data;
            r_idx <= (r_idx == w_last_idx) ? 5'd0 : r_idx + 5'd1;
          end
        end
        S_LOAD_B: begin
          if (w_in_hs) begin
            r_b[w_idx_lsb +: 8] <= in_data;
            r_idx <= (r_idx == w_last_idx) ? 5'd0 : r_idx + 5'd1;
          end
        end
        S_COMPUTE: begin
          r_res <= add_result;
          r_ovf <= add_overflow;
          r_k   <= 5'd0;
        end
        S_DRAIN: begin
          if (w_out_hs) begin
            if (r_k == w_last_idx) begin
              r_k    <= 5'd0;
              r_done <= 1'b1;
            end else begin
              r_k <= r_k + 5'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_matrix_add_ctrl.sv
// tb_matrix_add_ctrl: directed runs of matrix_add_ctrl against a queue-based result model.
`default_nettype none

module tb_matrix_add_ctrl;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [1:0]   size;
  logic         in_valid;
  logic         in_ready;
  logic [7:0]   in_data;
  logic [199:0] add_a;
  logic [199:0] add_b;
  logic [1:0]   add_size;
  logic [199:0] add_result;
  logic         add_overflow;
  logic         out_valid;
  logic         out_ready;
  logic [7:0]   out_data;
  logic         out_last;
  logic         out_ovf;
  logic         busy;
  logic         done;
  logic         overflow;

  matrix_add_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .size         (size),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .add_a        (add_a),
    .add_b        (add_b),
    .add_size     (add_size),
    .add_result   (add_result),
    .add_overflow (add_overflow),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_last     (out_last),
    .out_ovf      (out_ovf),
    .busy         (busy),
    .done         (done),
    .overflow     (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in for the external adder: element-wise wrapping sum, any-element overflow.
  always_comb begin
    add_result   = '0;
    add_overflow = 1'b0;
    for (int i = 0; i < 25; i++) begin
      add_result[8*i +: 8] = add_a[8*i +: 8] + add_b[8*i +: 8];
      if ((int'($signed(add_a[8*i +: 8])) + int'($signed(add_b[8*i +: 8]))) > 127 ||
          (int'($signed(add_a[8*i +: 8])) + int'($signed(add_b[8*i +: 8]))) < -128)
        add_overflow = 1'b1;
    end
  end

  typedef struct {
    logic [7:0] d;
    logic       l;
    logic       o;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] ta[25];
  logic [7:0] tb[25];
  logic [7:0] got_data[32];
  int         got_n;
  int         done_cnt;
  logic       exp_agg;
  int         checks;
  int         failures;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (done) begin
        done_cnt++;
        chk("busy_low_with_done", {31'd0, busy}, 32'd0);
      end
      if (out_valid) begin
        chk("in_ready_low_in_drain", {31'd0, in_ready}, 32'd0);
        if (exp_q.size() == 0) begin
          chk("unexpected_output", {31'd0, out_valid}, 32'd0);
        end else begin
          chk("out_data", {24'd0, out_data}, {24'd0, exp_q[0].d});
          chk("out_last", {31'd0, out_last}, {31'd0, exp_q[0].l});
          chk("out_ovf", {31'd0, out_ovf}, {31'd0, exp_q[0].o});
          if (out_ready) begin
            if (got_n < 32) got_data[got_n] = out_data;
            got_n++;
            void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  task automatic push(input logic [7:0] d);
    int t;
    t = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready) begin
      @(posedge clk); #1;
      t++;
      if (t > 50) begin
        chk("push_timeout", 32'd1, 32'd0);
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = 8'h00;
  endtask

  // Builds the expected stream from ta/tb, then starts and loads a run.
  // stop_b >= 0 abandons the run after that many B elements.
  task automatic load_run(input logic [1:0] sz, input int gap, input bit pulse_in_b, input int stop_b);
    int cnt;
    int s;
    logic ov;
    cnt = (int'(sz) + 2) * (int'(sz) + 2);
    exp_agg = 1'b0;
    got_n = 0;
    for (int k = 0; k < cnt; k++) begin
      s  = int'($signed(ta[k])) + int'($signed(tb[k]));
      ov = (s > 127) || (s < -128);
      if (ov) exp_agg = 1'b1;
`ifdef MADD_ELEM_OVF_EN
      exp_q.push_back('{d: s[7:0], l: (k == cnt - 1), o: ov});
`else
      exp_q.push_back('{d: s[7:0], l: (k == cnt - 1), o: 1'b0});
`endif
    end
    size  = sz;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    size  = ~sz;
    chk("in_ready_after_start", {31'd0, in_ready}, 32'd1);
    chk("busy_after_start", {31'd0, busy}, 32'd1);
    for (int k = 0; k < cnt; k++) begin
      push(ta[k]);
      repeat (gap) @(posedge clk);
      if (gap > 0) #1;
    end
    for (int k = 0; k < cnt; k++) begin
      if (stop_b >= 0 && k == stop_b) return;
      push(tb[k]);
      if (pulse_in_b && k == 1) begin
        size  = 2'b11;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("in_ready_after_ignored_start", {31'd0, in_ready}, 32'd1);
      end
      if (k != cnt - 1) begin
        repeat (gap) @(posedge clk);
        if (gap > 0) #1;
      end
    end
    chk("out_valid_low_in_compute", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    chk("out_valid_two_after_last_b", {31'd0, out_valid}, 32'd1);
  endtask

  task automatic drain(input int cnt, input int stall_k, input int stall_n);
    int  got;
    int  t;
    int  d0;
    int  stalls;
    bit  hs;
    got    = 0;
    t      = 0;
    stalls = stall_n;
    d0     = done_cnt;
    while (got < cnt) begin
      if (got == stall_k && stalls > 0) begin
        out_ready = 1'b0;
        stalls--;
      end else begin
        out_ready = 1'b1;
      end
      hs = out_valid && out_ready;
      @(posedge clk); #1;
      if (hs) got++;
      t++;
      if (t > 200) begin
        chk("drain_timeout", 32'd1, 32'd0);
        break;
      end
    end
    out_ready = 1'b0;
    chk("done_after_last", {31'd0, done}, 32'd1);
    chk("busy_in_done_cycle", {31'd0, busy}, 32'd0);
    chk("overflow_reg", {31'd0, overflow}, {31'd0, exp_agg});
    @(posedge clk); #1;
    chk("done_single_pulse", {31'd0, done}, 32'd0);
    chk("done_count", done_cnt - d0, 32'd1);
    chk("outputs_consumed", exp_q.size(), 32'd0);
  endtask

  task automatic set_2x2();
    for (int k = 0; k < 25; k++) begin
      ta[k] = 8'd0;
      tb[k] = 8'd0;
    end
    ta[0] = 8'd1;  ta[1] = 8'd2;  ta[2] = 8'd3;  ta[3] = 8'd4;
    tb[0] = 8'd10; tb[1] = 8'd20; tb[2] = 8'd30; tb[3] = 8'd40;
  endtask

  initial begin
    int d0;
    checks    = 0;
    failures  = 0;
    done_cnt  = 0;
    got_n     = 0;
    rst_n     = 1'b0;
    start     = 1'b0;
    size      = 2'b00;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_last", {31'd0, out_last}, 32'd0);
    chk("rst_out_ovf", {31'd0, out_ovf}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_overflow", {31'd0, overflow}, 32'd0);
    chk("rst_add_size", {30'd0, add_size}, 32'd0);
    chk("rst_add_a_zero", {31'd0, |add_a}, 32'd0);
    chk("rst_add_b_zero", {31'd0, |add_b}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 2x2 basic
    set_2x2();
    load_run(2'b00, 0, 1'b0, -1);
    drain(4, -1, 0);
    chk("2x2_e0", {24'd0, got_data[0]}, 32'd11);
    chk("2x2_e1", {24'd0, got_data[1]}, 32'd22);
    chk("2x2_e2", {24'd0, got_data[2]}, 32'd33);
    chk("2x2_e3", {24'd0, got_data[3]}, 32'd44);

    // 5x5 with overflow on the final element
    for (int k = 0; k < 25; k++) begin
      ta[k] = 8'd1;
      tb[k] = 8'd1;
    end
    ta[24] = 8'd127;
    load_run(2'b11, 0, 1'b0, -1);
    drain(25, -1, 0);
    chk("5x5_e0", {24'd0, got_data[0]}, 32'd2);
    chk("5x5_e23", {24'd0, got_data[23]}, 32'd2);
    chk("5x5_e24", {24'd0, got_data[24]}, 32'h80);
    chk("5x5_overflow", {31'd0, overflow}, 32'd1);

    // 3x3 with backpressure at k=4
    for (int k = 0; k < 25; k++) begin
      ta[k] = (k < 9) ? 8'(k + 1) : 8'd0;
      tb[k] = (k < 9) ? 8'(2 * k) : 8'd0;
    end
    load_run(2'b01, 0, 1'b0, -1);
    drain(9, 4, 3);
    chk("3x3_count", got_n, 32'd9);
    chk("3x3_e4", {24'd0, got_data[4]}, 32'd13);
    chk("3x3_e8", {24'd0, got_data[8]}, 32'd25);

    // 2x2 with a stray start during LOAD_B
    set_2x2();
    load_run(2'b00, 0, 1'b1, -1);
    chk("add_a_upper_zero", {31'd0, |add_a[199:32]}, 32'd0);
    chk("add_size_kept", {30'd0, add_size}, 32'd0);
    drain(4, -1, 0);
    chk("stray_start_count", got_n, 32'd4);

    // Reset during LOAD_B after two B elements
    set_2x2();
    load_run(2'b00, 0, 1'b0, 2);
    exp_q.delete();
    d0 = done_cnt;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_in_ready", {31'd0, in_ready}, 32'd0);
    chk("abort_add_a_zero", {31'd0, |add_a}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("abort_no_done", done_cnt - d0, 32'd0);
    chk("abort_no_output", {31'd0, out_valid}, 32'd0);
    load_run(2'b00, 0, 1'b0, -1);
    drain(4, -1, 0);
    chk("rerun_e0", {24'd0, got_data[0]}, 32'd11);
    chk("rerun_e3", {24'd0, got_data[3]}, 32'd44);

    // 4x4 with gaps between every element
    for (int k = 0; k < 25; k++) begin
      ta[k] = (k < 16) ? 8'(8'(k) - 8'd8) : 8'd0;
      tb[k] = (k < 16) ? 8'(3 * k) : 8'd0;
    end
    load_run(2'b10, 1, 1'b0, -1);
    drain(16, -1, 0);
    chk("4x4_count", got_n, 32'd16);
    chk("4x4_e0", {24'd0, got_data[0]}, 32'hF8);
    chk("4x4_e15", {24'd0, got_data[15]}, 32'd52);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
